cargador_mascara: RTL and testbench
===================================

CARGADOR_MASCARA -- requirements
Module: cargador_mascara

Interface
REQ-001 SHALL have parameter BITS_BUS_DATOS, default 21, width of one mask coefficient word.
REQ-002 SHALL have parameter BITS_DIRECCION_MEM, default 10, width of the memory address.
REQ-003 SHALL have parameter BITS_MASCARA, default 3, width of the mask side length N.
REQ-004 SHALL have parameter BITS_INDICE, default 6, width of the coefficient index; it must hold N*N-1 for N = 2^BITS_MASCARA-1.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic updates on its rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port iniciar, input, 1, load request pulse, driven by the mask-change signal of the mask register block.
REQ-008 SHALL have port direccion_mem_inicio_mascara, input, BITS_DIRECCION_MEM, first memory word of the mask.
REQ-009 SHALL have port tamano_mascara, input, BITS_MASCARA, mask side length N.
REQ-010 SHALL have port direccion_mem, output, BITS_DIRECCION_MEM, memory read address.
REQ-011 SHALL have port lectura_mem, output, 1, memory read strobe.
REQ-012 SHALL have port datos_mem, input, BITS_BUS_DATOS, memory read data, valid exactly 1 cycle after lectura_mem.
REQ-013 SHALL have port escritura_coeficiente, output, 1, coefficient bank write enable.
REQ-014 SHALL have port indice_coeficiente, output, BITS_INDICE, coefficient bank write index.
REQ-015 SHALL have port coeficiente, output, BITS_BUS_DATOS, coefficient bank write data; combinational pass-through of datos_mem.
REQ-016 SHALL have port ocupado, output, 1, load in progress.
REQ-017 SHALL have port listo, output, 1, one-cycle load-complete pulse.

Function
REQ-018 SHALL implement FSM states REPOSO, LECTURA and DRENADO.
REQ-019 In REPOSO with iniciar=1 and N!=0: SHALL latch base=direccion_mem_inicio_mascara and total T=N*N (computed at full BITS_INDICE width, no truncation), then enter LECTURA.
REQ-020 In REPOSO with iniciar=1 and N=0: SHALL issue no reads and no writes, pulse listo in the next cycle, and stay in REPOSO.
REQ-021 Timing, with iniciar sampled in cycle 0: lectura_mem=1 in cycles 1..T; direccion_mem in cycle k = (base+k-1) mod 2^BITS_DIRECCION_MEM, wrapping at the top of memory.
REQ-022 escritura_coeficiente SHALL be lectura_mem registered by one cycle (writes in cycles 2..T+1); indice_coeficiente in cycle k+1 = k-1.
REQ-023 SHALL move LECTURA -> DRENADO after the cycle that issues read index T-1, and DRENADO -> REPOSO after one cycle.
REQ-024 ocupado SHALL be 1 in cycles 1..T+1 and 0 otherwise; listo SHALL be 1 in cycle T+2 only.
REQ-025 All outputs except coeficiente SHALL be registered.
REQ-026 iniciar in LECTURA or DRENADO SHALL restart the load: relatch base and N, and begin reads at index 0 in the following cycle. The write that the aborted pass would produce in that cycle SHALL be suppressed. No listo SHALL be issued for the aborted pass.
REQ-027 iniciar asserted for consecutive cycles SHALL be treated as a restart on each sampled cycle.
REQ-028 Changes to direccion_mem_inicio_mascara or tamano_mascara while no iniciar is sampled SHALL NOT affect a load in progress.

Reset
REQ-029 reset=1 SHALL have priority over iniciar.
REQ-030 On reset=1, state SHALL become REPOSO on the next edge, and all counters and outputs SHALL clear.
REQ-031 Reset values: lectura_mem=0, escritura_coeficiente=0, ocupado=0, listo=0, direccion_mem=0, indice_coeficiente=0.
REQ-032 Reset mid-load SHALL abandon the load with no listo; the in-flight write SHALL be suppressed.

Verification
REQ-033 N=3, base=0x010, iniciar in cycle 0 -> reads 0x010..0x018 in cycles 1-9; writes of index 0..8 in cycles 2-10 carrying the mem data; listo in cycle 11.
REQ-034 N=3, base=0x3FE -> read addresses 0x3FE, 0x3FF, 0x000..0x006; indices 0..8.
REQ-035 N=7, base=0 -> 49 reads and 49 writes with indices 0..48; listo in cycle 51.
REQ-036 N=0 -> no lectura_mem and no escritura_coeficiente; listo in cycle 1; ocupado stays 0.
REQ-037 N=3 load, then iniciar in cycle 4 with base=0x100 and N=2 -> cycle 5: no write, read 0x100; reads 0x100..0x103 in cycles 5-8; writes of index 0..3 in cycles 6-9; listo in cycle 10 only.
REQ-038 reset in cycle 5 of an N=3 load -> from cycle 6 all outputs are 0; no listo; a later iniciar starts a clean load.

Source files
------------

// File: rtl/cargador_mascara.sv
// Loads an N x N convolution mask from memory into the coefficient bank, one word per cycle.
// Reads are issued back to back; each write follows its read by one cycle (memory latency).
//
// state   | meaning
// --------+-----------------------------------------------------------
// REPOSO  | idle, waiting for iniciar
// LECTURA | issuing reads of coefficient indices 0..T-1
// DRENADO | last read in flight, its write is issued; listo follows

module cargador_mascara #(
    parameter int BITS_BUS_DATOS     = 21,
    parameter int BITS_DIRECCION_MEM = 10,
    parameter int BITS_MASCARA       = 3,
    parameter int BITS_INDICE        = 6
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          iniciar,
    input  logic [BITS_DIRECCION_MEM-1:0] direccion_mem_inicio_mascara,
    input  logic [BITS_MASCARA-1:0]       tamano_mascara,
    output logic [BITS_DIRECCION_MEM-1:0] direccion_mem,
    output logic                          lectura_mem,
    input  logic [BITS_BUS_DATOS-1:0]     datos_mem,
    output logic                          escritura_coeficiente,
    output logic [BITS_INDICE-1:0]        indice_coeficiente,
    output logic [BITS_BUS_DATOS-1:0]     coeficiente,
    output logic                          ocupado,
    output logic                          listo
);

    typedef enum logic [1:0] {
        REPOSO  = 2'd0,
        LECTURA = 2'd1,
        DRENADO = 2'd2
    } estado_t;

    estado_t                       estado, estado_sig;
    logic [BITS_DIRECCION_MEM-1:0] direccion_sig;
    logic                          lectura_sig;
    logic                          escritura_sig;
    logic [BITS_INDICE-1:0]        indice_sig;
    logic                          ocupado_sig;
    logic                          listo_sig;
    logic [BITS_INDICE-1:0]        indice_lectura, indice_lectura_sig;
    logic [BITS_INDICE-1:0]        restantes, restantes_sig;
    logic [BITS_INDICE-1:0]        lado;
    logic [BITS_INDICE-1:0]        total_menos_uno;

    // Side length widened before squaring so N*N is never truncated to BITS_MASCARA.
    assign lado            = BITS_INDICE'(tamano_mascara);
    assign total_menos_uno = (lado * lado) - BITS_INDICE'(1);

    assign coeficiente = datos_mem;

    always_comb begin
        estado_sig         = estado;
        direccion_sig      = direccion_mem;
        lectura_sig        = 1'b0;
        escritura_sig      = lectura_mem;
        indice_sig         = lectura_mem ? indice_lectura : indice_coeficiente;
        ocupado_sig        = 1'b0;
        listo_sig          = 1'b0;
        indice_lectura_sig = indice_lectura;
        restantes_sig      = restantes;

        if (iniciar) begin
            // A new request always wins; the write of the abandoned pass is dropped.
            escritura_sig = 1'b0;
            if (tamano_mascara != '0) begin
                estado_sig         = LECTURA;
                direccion_sig      = direccion_mem_inicio_mascara;
                lectura_sig        = 1'b1;
                indice_lectura_sig = '0;
                restantes_sig      = total_menos_uno;
                ocupado_sig        = 1'b1;
            end else begin
                estado_sig = REPOSO;
                listo_sig  = 1'b1;
            end
        end else begin
            unique case (estado)
                REPOSO: begin
                    estado_sig = REPOSO;
                end
                LECTURA: begin
                    ocupado_sig = 1'b1;
                    if (restantes == '0) begin
                        estado_sig = DRENADO;
                    end else begin
                        lectura_sig        = 1'b1;
                        direccion_sig      = direccion_mem + BITS_DIRECCION_MEM'(1);
                        indice_lectura_sig = indice_lectura + BITS_INDICE'(1);
                        restantes_sig      = restantes - BITS_INDICE'(1);
                    end
                end
                DRENADO: begin
                    estado_sig = REPOSO;
                    listo_sig  = 1'b1;
                end
                default: begin
                    estado_sig = REPOSO;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado                <= REPOSO;
            direccion_mem         <= '0;
            lectura_mem           <= 1'b0;
            escritura_coeficiente <= 1'b0;
            indice_coeficiente    <= '0;
            ocupado               <= 1'b0;
            listo                 <= 1'b0;
            indice_lectura        <= '0;
            restantes             <= '0;
        end else begin
            estado                <= estado_sig;
            direccion_mem         <= direccion_sig;
            lectura_mem           <= lectura_sig;
            escritura_coeficiente <= escritura_sig;
            indice_coeficiente    <= indice_sig;
            ocupado               <= ocupado_sig;
            listo                 <= listo_sig;
            indice_lectura        <= indice_lectura_sig;
            restantes             <= restantes_sig;
        end
    end

endmodule

// File: tb/tb_cargador_mascara.sv
// Directed bench for cargador_mascara: a scoreboard of expected reads, writes and listo
// pulses is filled when each load is requested and drained cycle by cycle against the DUT.

module tb_cargador_mascara;

    logic        clk = 1'b0;
    logic        reset;
    logic        iniciar;
    logic [9:0]  direccion_mem_inicio_mascara;
    logic [2:0]  tamano_mascara;
    logic [9:0]  direccion_mem;
    logic        lectura_mem;
    logic [20:0] datos_mem;
    logic        escritura_coeficiente;
    logic [5:0]  indice_coeficiente;
    logic [20:0] coeficiente;
    logic        ocupado;
    logic        listo;

    cargador_mascara dut (
        .clk                          (clk),
        .reset                        (reset),
        .iniciar                      (iniciar),
        .direccion_mem_inicio_mascara (direccion_mem_inicio_mascara),
        .tamano_mascara               (tamano_mascara),
        .direccion_mem                (direccion_mem),
        .lectura_mem                  (lectura_mem),
        .datos_mem                    (datos_mem),
        .escritura_coeficiente        (escritura_coeficiente),
        .indice_coeficiente           (indice_coeficiente),
        .coeficiente                  (coeficiente),
        .ocupado                      (ocupado),
        .listo                        (listo)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         ciclo;
        logic [9:0] dir;
    } lect_t;

    typedef struct {
        int          ciclo;
        logic [5:0]  idx;
        logic [20:0] dato;
    } esc_t;

    lect_t cola_lect[$];
    esc_t  cola_esc[$];
    int    cola_listo[$];
    int    ciclo;
    int    ocup_ini;
    int    ocup_fin;
    int    checks;
    int    errores;

    function automatic logic [20:0] mem_f(input logic [9:0] a);
        return {a, a ^ 10'h2A5, ^a};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errores++;
            $error("FAIL %s ciclo=%0d observed=%0h expected=%0h", tag, ciclo, obs, exp);
        end
    endtask

    task automatic purgar(input int r);
        while (cola_lect.size() > 0 && cola_lect[$].ciclo > r) void'(cola_lect.pop_back());
        while (cola_esc.size() > 0 && cola_esc[$].ciclo > r) void'(cola_esc.pop_back());
        while (cola_listo.size() > 0 && cola_listo[$] > r) void'(cola_listo.pop_back());
    endtask

    // Request a load in the current cycle: drive inputs and record the expected behaviour.
    task automatic cargar(input logic [9:0] base, input logic [2:0] n);
        int   r;
        int   t;
        logic [9:0] a;
        r = ciclo;
        iniciar = 1'b1;
        direccion_mem_inicio_mascara = base;
        tamano_mascara = n;
        purgar(r);
        if (n == 3'd0) begin
            cola_listo.push_back(r + 1);
            if (ocup_fin > r) ocup_fin = r;
        end else begin
            t = int'(n) * int'(n);
            for (int k = 1; k <= t; k++) begin
                a = base + 10'(k - 1);
                cola_lect.push_back('{ciclo: r + k, dir: a});
                cola_esc.push_back('{ciclo: r + k + 1, idx: 6'(k - 1), dato: mem_f(a)});
            end
            cola_listo.push_back(r + t + 2);
            if (!(ocup_ini <= r && r <= ocup_fin)) ocup_ini = r + 1;
            ocup_fin = r + t + 1;
        end
    endtask

    task automatic comprobar();
        logic exp_l;
        logic exp_e;
        logic exp_f;
        exp_l = (cola_lect.size() > 0) && (cola_lect[0].ciclo == ciclo);
        chk("lectura_mem", 32'(lectura_mem), 32'(exp_l));
        if (exp_l) begin
            if (lectura_mem) chk("direccion_mem", 32'(direccion_mem), 32'(cola_lect[0].dir));
            void'(cola_lect.pop_front());
        end
        exp_e = (cola_esc.size() > 0) && (cola_esc[0].ciclo == ciclo);
        chk("escritura", 32'(escritura_coeficiente), 32'(exp_e));
        if (exp_e) begin
            if (escritura_coeficiente) begin
                chk("indice", 32'(indice_coeficiente), 32'(cola_esc[0].idx));
                chk("coeficiente", 32'(coeficiente), 32'(cola_esc[0].dato));
            end
            void'(cola_esc.pop_front());
        end
        exp_f = (cola_listo.size() > 0) && (cola_listo[0] == ciclo);
        chk("listo", 32'(listo), 32'(exp_f));
        if (exp_f) void'(cola_listo.pop_front());
        chk("ocupado", 32'(ocupado), 32'((ciclo >= ocup_ini) && (ciclo <= ocup_fin)));
    endtask

    // One clock cycle: memory model answers the previous cycle's read, then outputs are checked.
    task automatic paso();
        logic       l;
        logic [9:0] d;
        l = lectura_mem;
        d = direccion_mem;
        @(posedge clk);
        datos_mem = l ? mem_f(d) : '0;
        ciclo++;
        #1;
        comprobar();
    endtask

    task automatic pasos(input int n);
        for (int i = 0; i < n; i++) paso();
    endtask

    initial begin
        reset = 1'b1;
        iniciar = 1'b0;
        direccion_mem_inicio_mascara = '0;
        tamano_mascara = '0;
        datos_mem = '0;
        ciclo = 0;
        ocup_ini = 1;
        ocup_fin = 0;
        checks = 0;
        errores = 0;

        // Reset state, with a stray iniciar that reset must override.
        iniciar = 1'b1;
        tamano_mascara = 3'd3;
        pasos(3);
        chk("reset_direccion", 32'(direccion_mem), 32'h0);
        chk("reset_indice", 32'(indice_coeficiente), 32'h0);
        iniciar = 1'b0;
        reset = 1'b0;
        pasos(2);

        // N=3 from 0x010; inputs changed afterwards must not disturb the load.
        cargar(10'h010, 3'd3);
        paso();
        iniciar = 1'b0;
        direccion_mem_inicio_mascara = 10'h2AA;
        tamano_mascara = 3'd5;
        pasos(14);

        // Wrap at the top of memory.
        cargar(10'h3FE, 3'd3);
        paso();
        iniciar = 1'b0;
        pasos(13);

        // Largest mask.
        cargar(10'h000, 3'd7);
        paso();
        iniciar = 1'b0;
        pasos(55);

        // Empty mask.
        cargar(10'h123, 3'd0);
        paso();
        iniciar = 1'b0;
        pasos(4);

        // Restart in LECTURA (cycle 4 of an N=3 load).
        cargar(10'h020, 3'd3);
        paso();
        iniciar = 1'b0;
        pasos(3);
        cargar(10'h100, 3'd2);
        paso();
        iniciar = 1'b0;
        pasos(12);

        // Consecutive iniciar cycles, each a restart.
        cargar(10'h040, 3'd2);
        paso();
        cargar(10'h060, 3'd3);
        paso();
        cargar(10'h080, 3'd2);
        paso();
        iniciar = 1'b0;
        pasos(10);

        // Restart during DRENADO of an N=1 load.
        cargar(10'h005, 3'd1);
        paso();
        iniciar = 1'b0;
        paso();
        cargar(10'h200, 3'd2);
        paso();
        iniciar = 1'b0;
        pasos(10);

        // Reset in cycle 5 of an N=3 load, with iniciar also high, then a clean load.
        cargar(10'h030, 3'd3);
        paso();
        iniciar = 1'b0;
        pasos(4);
        reset = 1'b1;
        iniciar = 1'b1;
        purgar(ciclo);
        if (ocup_fin > ciclo) ocup_fin = ciclo;
        paso();
        chk("rst_direccion", 32'(direccion_mem), 32'h0);
        chk("rst_indice", 32'(indice_coeficiente), 32'h0);
        reset = 1'b0;
        iniciar = 1'b0;
        pasos(6);
        cargar(10'h050, 3'd2);
        paso();
        iniciar = 1'b0;
        pasos(10);

        chk("cola_lect_vacia", 32'(cola_lect.size()), 32'h0);
        chk("cola_esc_vacia", 32'(cola_esc.size()), 32'h0);
        chk("cola_listo_vacia", 32'(cola_listo.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errores);
        $finish;
    end

endmodule
